mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the IF stage (instruction fetch) and
//  the MEM stage (load/store) of the 5-stage pipeline. Data accesses win over fetch.
//  Each access is held for a fixed MEM_LAT cycles. The block raises stall_if and
//  stall_mem; the hazard unit ORs these into StallF/StallD/StallE/StallM.
//  A per-side done flag holds a served result until the pipeline advances.
// PARAMETERS
//  W        32  data and address width
//  MEM_LAT  2   memory access cycles (>=1); mem_rdata is valid on the last cycle
// PORTS
//  clk        in   1  single clock; all state updates on the rising edge
//  reset      in   1  synchronous, active-high
//  if_req     in   1  IF stage needs an instruction word
//  if_addr    in   W  fetch address (PCF)
//  if_ready   out  1  fetch word valid this cycle
//  if_rdata   out  W  fetched instruction
//  dm_req     in   1  MEM stage needs a load or store
//  dm_we      in   1  1 = store, 0 = load
//  dm_addr    in   W  data address (ALUOutM)
//  dm_wdata   in   W  store data (WriteDataM)
//  dm_ready   out  1  data access complete this cycle
//  dm_rdata   out  W  load result
//  pipe_adv   in   1  pipeline registers advance this cycle (hazard unit ~StallF)
//  stall_if   out  1  if_req & ~if_ready
//  stall_mem  out  1  dm_req & ~dm_ready
//  mem_en     out  1  memory access active
//  mem_we     out  1  memory write strobe (only while mem_en)
//  mem_addr   out  W  latched access address
//  mem_wdata  out  W  latched store data
//  mem_rdata  in   W  memory read data, valid on the final access cycle
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, if_done=dm_done=0, held rdata regs=0.
//    mem_en, mem_we, if_ready and dm_ready all 0. Reset mid-access aborts the access;
//    mem_en is low from the next cycle and no ready is issued.
//  - FSM IDLE/IBUSY/DBUSY. A grant is made only from IDLE:
//    - dm_req & ~dm_done -> DBUSY: latch dm_addr/dm_we/dm_wdata, cnt=MEM_LAT-1.
//    - else if_req & ~if_done -> IBUSY: latch if_addr, cnt=MEM_LAT-1, we=0.
//  - In BUSY: mem_en=1 and mem_addr/mem_we/mem_wdata come from latched regs only.
//    cnt decrements each cycle. On cnt==0 the access completes:
//    - ready for the served side is asserted combinationally.
//    - rdata passes mem_rdata through and is captured into that side's hold reg.
//    - the side's done flag is set (unless pipe_adv is high the same cycle).
//    - next state is IDLE (one arbitration cycle between accesses).
//  - Latency: request seen in IDLE at cycle t -> ready in cycle t+MEM_LAT.
//  - While X_done=1: X_ready=1 and X_rdata=hold reg. No new access is issued for side X.
//  - pipe_adv=1 clears both done flags at the edge. A completion in the same cycle as
//    pipe_adv does not set done.
//  - A store (dm_we=1) completes like a load. dm_rdata is don't-care and the hold reg
//    is still written.
//  - Simultaneous if_req and dm_req in IDLE: data is granted first. Fetch waits.
//    No starvation: dm_done blocks re-issue until pipe_adv.
//  - pipe_adv=1 while a requesting side has ready=0 is a protocol violation.
//    Flag it with a simulation assertion; RTL behaviour is undefined.
//  - A request dropping while BUSY does not abort the access. Completion still sets done.
//  - cnt width is clog2(MEM_LAT)+1. It never wraps because it is reloaded only on grant.
// STRUCTURE
//  - Shared header mem_arb_defs.vh: state encodings ARB_IDLE=2'd0, ARB_IBUSY=2'd1,
//    ARB_DBUSY=2'd2, plus the MEM_LAT default.
//  - Sub-module arb_req_slot, instantiated twice (IF, DM). It holds the done flag and
//    rdata hold reg, and produces ready/rdata muxing from completion/pipe_adv inputs.
//  - Top level holds the FSM, counter, address/data latches and stall logic.
// TESTING
//  1. MEM_LAT=2, if_req=1 at addr 0x0, pipe_adv=0 -> mem_en cycles 1-2; if_ready=1
//     from cycle 2 with rdata=mem word[0]; if_done holds it; stall_if=0 from cycle 2.
//  2. if_req and dm_req (load 0x40) both at t=0 -> DBUSY first, dm_ready at t=2.
//     IDLE at t=3 then IBUSY; if_ready at t=5; stall_if high t=0..4.
//  3. Store dm_we=1, addr 0x44, wdata 0xDEADBEEF -> mem_we=1, mem_addr=0x44 for 2 cycles.
//     Then a load of 0x44 returns 0xDEADBEEF.
//  4. pipe_adv held 0 for 5 cycles after completion -> ready stays 1, rdata stable,
//     mem_en=0 (no re-issue). pipe_adv=1 -> done cleared; next if_req starts a new access.
//  5. reset=1 during DBUSY cnt=1 -> next cycle mem_en=0, dm_ready=0, state IDLE,
//     done flags 0.
//  6. MEM_LAT=1 back-to-back fetches with pipe_adv=1 on each ready -> one access every
//     2 cycles, addresses in order.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM single-port memory arbiter: FSM encodings and default access latency.
package mem_port_arbiter_pkg;

   localparam int MEM_LAT_DEF = 2;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_IBUSY = 2'd1,
      ARB_DBUSY = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_slot.sv
// Per-requester result slot: ready/rdata pass-through on completion, then held until pipe_adv.
// Zero latency from completion to ready; holds ready high indefinitely while the pipeline stalls.
module arb_req_slot #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         complete,
   input  logic         pipe_adv,
   input  logic [W-1:0] mem_rdata,
   output logic         ready,
   output logic [W-1:0] rdata,
   output logic         done
);

   logic [W-1:0] hold;

   // A completion coinciding with pipe_adv is consumed immediately, so done stays clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         done <= 1'b0;
         hold <= '0;
      end else begin
         if (complete) hold <= mem_rdata;
         if (pipe_adv)      done <= 1'b0;
         else if (complete) done <= 1'b1;
      end
   end

   assign ready = complete | done;
   assign rdata = complete ? mem_rdata : hold;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch and data; data wins, each access lasts MEM_LAT cycles.
// Ready arrives MEM_LAT cycles after an IDLE grant; a served side holds ready until pipe_adv, blocking re-issue.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int W       = 32,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         if_req,
   input  logic [W-1:0] if_addr,
   output logic         if_ready,
   output logic [W-1:0] if_rdata,
   input  logic         dm_req,
   input  logic         dm_we,
   input  logic [W-1:0] dm_addr,
   input  logic [W-1:0] dm_wdata,
   output logic         dm_ready,
   output logic [W-1:0] dm_rdata,
   input  logic         pipe_adv,
   output logic         stall_if,
   output logic         stall_mem,
   output logic         mem_en,
   output logic         mem_we,
   output logic [W-1:0] mem_addr,
   output logic [W-1:0] mem_wdata,
   input  logic [W-1:0] mem_rdata
);

   localparam int CW = $clog2(MEM_LAT) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

   arb_state_t    state, state_nxt;
   logic [CW-1:0] cnt;
   logic [W-1:0]  lat_addr, lat_wdata;
   logic          lat_we;
   logic          grant_if, grant_dm;
   logic          busy, last, if_cmp, dm_cmp;
   logic          if_done, dm_done;

   assign busy   = (state != ARB_IDLE);
   assign last   = busy && (cnt == '0);
   assign if_cmp = last && (state == ARB_IBUSY);
   assign dm_cmp = last && (state == ARB_DBUSY);

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (dm_req && !dm_done) begin
               state_nxt = ARB_DBUSY;
               grant_dm  = 1'b1;
            end else if (if_req && !if_done) begin
               state_nxt = ARB_IBUSY;
               grant_if  = 1'b1;
            end
         end
         ARB_IBUSY, ARB_DBUSY: begin
            if (cnt == '0) state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Counter reloads only on grant, so it cannot wrap below zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARB_IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_dm || grant_if) cnt <= CNT_LOAD;
         else if (busy && cnt != '0) cnt <= cnt - 1'b1;
         if (grant_dm) begin
            lat_addr  <= dm_addr;
            lat_wdata <= dm_wdata;
            lat_we    <= dm_we;
         end else if (grant_if) begin
            lat_addr <= if_addr;
            lat_we   <= 1'b0;
         end
      end
   end

   arb_req_slot #(.W(W)) u_if_slot (
      .clk(clk), .reset(reset), .complete(if_cmp), .pipe_adv(pipe_adv),
      .mem_rdata(mem_rdata), .ready(if_ready), .rdata(if_rdata), .done(if_done)
   );

   arb_req_slot #(.W(W)) u_dm_slot (
      .clk(clk), .reset(reset), .complete(dm_cmp), .pipe_adv(pipe_adv),
      .mem_rdata(mem_rdata), .ready(dm_ready), .rdata(dm_rdata), .done(dm_done)
   );

   assign mem_en    = busy;
   assign mem_we    = busy && lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = dm_req & ~dm_ready;

   // The pipeline must never advance past a stage still waiting on memory.
   assert property (@(posedge clk) disable iff (reset)
      !(pipe_adv && ((if_req && !if_ready) || (dm_req && !dm_ready))));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: MEM_LAT=2 instance for fetch/data/store/reset scenarios, MEM_LAT=1 instance for back-to-back fetch.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_we, pipe_adv;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic        if_ready, dm_ready, stall_if, stall_mem, mem_en, mem_we;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

   logic        if_req_b, pipe_adv_b;
   logic [31:0] if_addr_b;
   logic        if_ready_b, dm_ready_b, stall_if_b, stall_mem_b, mem_en_b, mem_we_b;
   logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

   logic [31:0] mem [0:255];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.W(32), .MEM_LAT(2)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ready(dm_ready), .dm_rdata(dm_rdata), .pipe_adv(pipe_adv),
      .stall_if(stall_if), .stall_mem(stall_mem), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.W(32), .MEM_LAT(1)) dut_b (
      .clk(clk), .reset(reset),
      .if_req(if_req_b), .if_addr(if_addr_b), .if_ready(if_ready_b), .if_rdata(if_rdata_b),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_ready(dm_ready_b), .dm_rdata(dm_rdata_b), .pipe_adv(pipe_adv_b),
      .stall_if(stall_if_b), .stall_mem(stall_mem_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
   );

   // Word i initialises to 0xA000_0000 | i; reset restores the image.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
      end else if (mem_en && mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end
   assign mem_rdata   = mem[mem_addr[9:2]];
   assign mem_rdata_b = 32'hB000_0000 ^ mem_addr_b;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; pipe_adv = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      if_req_b = 0; if_addr_b = 0; pipe_adv_b = 0;
      reset = 1;
      tick(); tick();
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%0h exp=0", mem_en); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0h exp=0", mem_we); end
      reset = 0;
      tick();
      checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL rst_if_ready got=%0h exp=0", if_ready); end
      checks++; if (dm_ready !== 1'b0) begin failures++; $display("FAIL rst_dm_ready got=%0h exp=0", dm_ready); end
      checks++; if (if_rdata !== 32'h0) begin failures++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
      checks++; if (mem_en_b !== 1'b0) begin failures++; $display("FAIL rst_b_mem_en got=%0h exp=0", mem_en_b); end
   endtask

   // Single fetch, then held result while stalled, then release and a fresh fetch.
   task automatic test_fetch_hold();
      if_req = 1; if_addr = 32'h0; #1;
      checks++; if (stall_if !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL f_c0 stall_if=%0h mem_en=%0h exp=1,0", stall_if, mem_en); end
      tick();
      checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0 || if_ready !== 1'b0) begin failures++; $display("FAIL f_c1 en=%0h addr=%h we=%0h rdy=%0h exp=1,0,0,0", mem_en, mem_addr, mem_we, if_ready); end
      tick();
      checks++; if (if_ready !== 1'b1 || if_rdata !== 32'hA000_0000 || stall_if !== 1'b0 || mem_en !== 1'b1) begin failures++; $display("FAIL f_c2 rdy=%0h rdata=%h stall=%0h en=%0h exp=1,a0000000,0,1", if_ready, if_rdata, stall_if, mem_en); end
      for (int c = 3; c < 8; c++) begin
         tick();
         checks++; if (if_ready !== 1'b1 || if_rdata !== 32'hA000_0000 || mem_en !== 1'b0) begin failures++; $display("FAIL hold_c%0d rdy=%0h rdata=%h en=%0h exp=1,a0000000,0", c, if_ready, if_rdata, mem_en); end
      end
      pipe_adv = 1;
      tick();
      pipe_adv = 0; if_addr = 32'h8; #1;
      checks++; if (if_ready !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL adv_clear rdy=%0h en=%0h exp=0,0", if_ready, mem_en); end
      tick();
      checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h8) begin failures++; $display("FAIL refetch_c1 en=%0h addr=%h exp=1,8", mem_en, mem_addr); end
      tick();
      checks++; if (if_ready !== 1'b1 || if_rdata !== 32'hA000_0002) begin failures++; $display("FAIL refetch_c2 rdy=%0h rdata=%h exp=1,a0000002", if_ready, if_rdata); end
      pipe_adv = 1;
      tick();
      idle_inputs();
   endtask

   task automatic test_priority();
      if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h40; #1;
      checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin failures++; $display("FAIL pri_c0 stall_if=%0h stall_mem=%0h exp=1,1", stall_if, stall_mem); end
      tick();
      checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin failures++; $display("FAIL pri_c1 en=%0h addr=%h exp=1,40", mem_en, mem_addr); end
      tick();
      checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hA000_0010 || stall_if !== 1'b1) begin failures++; $display("FAIL pri_c2 dm_rdy=%0h rdata=%h stall_if=%0h exp=1,a0000010,1", dm_ready, dm_rdata, stall_if); end
      tick();
      checks++; if (mem_en !== 1'b0 || dm_ready !== 1'b1 || stall_mem !== 1'b0 || stall_if !== 1'b1) begin failures++; $display("FAIL pri_c3 en=%0h dm_rdy=%0h stall_mem=%0h stall_if=%0h exp=0,1,0,1", mem_en, dm_ready, stall_mem, stall_if); end
      tick();
      checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10 || stall_if !== 1'b1) begin failures++; $display("FAIL pri_c4 en=%0h addr=%h stall_if=%0h exp=1,10,1", mem_en, mem_addr, stall_if); end
      tick();
      checks++; if (if_ready !== 1'b1 || if_rdata !== 32'hA000_0004 || stall_if !== 1'b0 || dm_ready !== 1'b1) begin failures++; $display("FAIL pri_c5 if_rdy=%0h rdata=%h stall_if=%0h dm_rdy=%0h exp=1,a0000004,0,1", if_ready, if_rdata, stall_if, dm_ready); end
      pipe_adv = 1;
      tick();
      idle_inputs(); #1;
      checks++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin failures++; $display("FAIL pri_c6 if_rdy=%0h dm_rdy=%0h exp=0,0", if_ready, dm_ready); end
   endtask

   task automatic test_store_load();
      dm_req = 1; dm_we = 1; dm_addr = 32'h44; dm_wdata = 32'hDEAD_BEEF;
      tick();
      dm_we = 0; dm_addr = 32'h80; dm_wdata = 32'h1234_5678; #1;
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h44 || mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL st_c1 we=%0h addr=%h wdata=%h exp=1,44,deadbeef", mem_we, mem_addr, mem_wdata); end
      tick();
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h44 || dm_ready !== 1'b1) begin failures++; $display("FAIL st_c2 we=%0h addr=%h rdy=%0h exp=1,44,1", mem_we, mem_addr, dm_ready); end
      pipe_adv = 1;
      tick();
      pipe_adv = 0; dm_we = 0; dm_addr = 32'h44;
      tick();
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h44) begin failures++; $display("FAIL ld_c1 en=%0h we=%0h addr=%h exp=1,0,44", mem_en, mem_we, mem_addr); end
      tick();
      checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ld_c2 rdy=%0h rdata=%h exp=1,deadbeef", dm_ready, dm_rdata); end
      tick();
      checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF || mem_en !== 1'b0) begin failures++; $display("FAIL ld_hold rdy=%0h rdata=%h en=%0h exp=1,deadbeef,0", dm_ready, dm_rdata, mem_en); end
   endtask

   // dm_done/hold still set from the load above; reset mid-access must clear everything.
   task automatic test_reset_abort();
      pipe_adv = 1;
      tick();
      pipe_adv = 0; dm_addr = 32'h48;
      tick();
      checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h48) begin failures++; $display("FAIL ab_c1 en=%0h addr=%h exp=1,48", mem_en, mem_addr); end
      reset = 1;
      tick();
      reset = 0; dm_req = 0; #1;
      checks++; if (mem_en !== 1'b0 || dm_ready !== 1'b0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL ab_c2 en=%0h rdy=%0h rdata=%h exp=0,0,0", mem_en, dm_ready, dm_rdata); end
      tick();
      checks++; if (mem_en !== 1'b0 || dm_ready !== 1'b0 || if_ready !== 1'b0) begin failures++; $display("FAIL ab_c3 en=%0h dm_rdy=%0h if_rdy=%0h exp=0,0,0", mem_en, dm_ready, if_ready); end
   endtask

   task automatic test_drop_while_busy();
      if_req = 1; if_addr = 32'h20;
      tick();
      if_req = 0;
      tick();
      checks++; if (if_ready !== 1'b1 || if_rdata !== 32'hA000_0008) begin failures++; $display("FAIL drop_c2 rdy=%0h rdata=%h exp=1,a0000008", if_ready, if_rdata); end
      tick();
      checks++; if (if_ready !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL drop_c3 rdy=%0h en=%0h exp=1,0", if_ready, mem_en); end
      pipe_adv = 1;
      tick();
      pipe_adv = 0; #1;
      checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL drop_clear rdy=%0h exp=0", if_ready); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc;
      int served;
      pc = 32'h100; served = 0;
      if_req_b = 1; if_addr_b = pc; pipe_adv_b = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++; if (if_ready_b !== c[0]) begin failures++; $display("FAIL b2b_rdy_c%0d got=%0h exp=%0h", c, if_ready_b, c[0]); end
         if (if_ready_b) begin
            checks++; if (if_rdata_b !== (32'hB000_0000 ^ pc) || mem_addr_b !== pc) begin failures++; $display("FAIL b2b_data_c%0d rdata=%h addr=%h exp=%h,%h", c, if_rdata_b, mem_addr_b, 32'hB000_0000 ^ pc, pc); end
            pipe_adv_b = 1;
            served++;
         end else begin
            pipe_adv_b = 0;
         end
         @(posedge clk);
         if (pipe_adv_b) pc = pc + 32'd4;
         if_addr_b = pc;
      end
      if_req_b = 0; pipe_adv_b = 0;
      checks++; if (served != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", served); end
   endtask

   initial begin
      test_reset();
      test_fetch_hold();
      test_priority();
      test_store_load();
      test_reset_abort();
      test_drop_while_busy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
